rtc_time_writer: RTL and testbench

// - Downstream of the time-edit stage: on a commit request, writes the edited BCD time (HC/MC/SC, AmPm, format)

---
 rtl/rtc_time_writer_if.sv | 30 +++
 rtl/rtc_time_writer.sv | 161 ++++++++++++++++
 tb/tb_rtc_time_writer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_time_writer_if.sv
// RTC write-path bundle: edited time/commit from the edit stage, multiplexed
// address/data bus plus status toward the RTC and the top-level bus mux.
interface rtc_time_writer_if;
    logic [7:0] HC;
    logic [7:0] MC;
    logic [7:0] SC;
    logic       AmPm;
    logic       format;
    logic       commit;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       busy;
    logic       done;

    // Edit stage / testbench side: supplies time and commit, observes bus.
    modport master (
        output HC, MC, SC, AmPm, format, commit,
        input  ad_out, ad_oe, a_d, cs_n, wr_n, rd_n, busy, done
    );

    // Writer side: consumes time and commit, owns the bus outputs.
    modport slave (
        input  HC, MC, SC, AmPm, format, commit,
        output ad_out, ad_oe, a_d, cs_n, wr_n, rd_n, busy, done
    );
endinterface

// File: rtl/rtc_time_writer.sv
// Writes a committed BCD time into the external RTC: SEC, MIN, HOUR, then the
// transfer/update command. Each transaction is an address phase followed by a
// data phase, each split into set / strobe / hold sub-phases of T_PH cycles.
// All bus outputs are registered from the next-state values so they never glitch.
module rtc_time_writer #(
    parameter int         T_PH      = 10,
    parameter logic [7:0] ADDR_SEC  = 8'h21,
    parameter logic [7:0] ADDR_MIN  = 8'h22,
    parameter logic [7:0] ADDR_HOUR = 8'h23,
    parameter logic [7:0] ADDR_CMD  = 8'hF2,
    parameter logic [7:0] CMD_DATA  = 8'hF2
) (
    input  logic               clk,
    input  logic               reset,
    rtc_time_writer_if.slave   rtc
);

    localparam int CW = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(T_PH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_A_SET, S_A_WR, S_A_HOLD, S_D_SET, S_D_WR, S_D_HOLD, S_DONE
    } state_t;

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_commit_ref;
    logic [7:0]      r_sec;
    logic [7:0]      r_min;
    logic [7:0]      r_hour;

    logic [7:0]      r_ad_out;
    logic            r_ad_oe;
    logic            r_a_d;
    logic            r_cs_n;
    logic            r_wr_n;
    logic            r_busy;
    logic            r_done;

    state_t          w_ns;
    logic [1:0]      w_nidx;
    logic [CW-1:0]   w_ncnt;
    logic            w_start;
    logic            w_last;
    logic            w_phase;
    logic            w_dph;
    logic            w_wr;
    logic [7:0]      w_addr;
    logic [7:0]      w_data;
    logic [7:0]      w_hour_in;

    assign w_start   = rtc.commit & ~r_commit_ref;
    assign w_last    = (r_cnt == CNT_LAST);
    // In 12 h mode the PM flag rides in bit 7 of the hour byte.
    assign w_hour_in = rtc.format ? {rtc.AmPm, rtc.HC[6:0]} : rtc.HC;

    // Next-state, transaction index and phase counter.
    always_comb begin
        w_ns   = r_state;
        w_nidx = r_idx;
        w_ncnt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_ns   = S_A_SET;
                    w_nidx = 2'd0;
                    w_ncnt = '0;
                end
            end
            S_DONE: w_ns = S_IDLE;
            default: begin
                if (w_last) begin
                    w_ncnt = '0;
                    case (r_state)
                        S_A_SET:  w_ns = S_A_WR;
                        S_A_WR:   w_ns = S_A_HOLD;
                        S_A_HOLD: w_ns = S_D_SET;
                        S_D_SET:  w_ns = S_D_WR;
                        S_D_WR:   w_ns = S_D_HOLD;
                        default: begin
                            // D_HOLD: the command transaction is the last one.
                            if (r_idx == 2'd3) begin
                                w_ns = S_DONE;
                            end else begin
                                w_ns   = S_A_SET;
                                w_nidx = r_idx + 2'd1;
                            end
                        end
                    endcase
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // Address and data byte for the transaction the next state belongs to.
    always_comb begin
        w_addr = ADDR_SEC;
        w_data = r_sec;
        case (w_nidx)
            2'd0: begin w_addr = ADDR_SEC;  w_data = r_sec;    end
            2'd1: begin w_addr = ADDR_MIN;  w_data = r_min;    end
            2'd2: begin w_addr = ADDR_HOUR; w_data = r_hour;   end
            default: begin w_addr = ADDR_CMD; w_data = CMD_DATA; end
        endcase
    end

    assign w_phase = (w_ns != S_IDLE) && (w_ns != S_DONE);
    assign w_dph   = (w_ns == S_D_SET) || (w_ns == S_D_WR) || (w_ns == S_D_HOLD);
    assign w_wr    = (w_ns == S_A_WR) || (w_ns == S_D_WR);

    // State, latched time bytes and registered bus outputs; reset drops the bus at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_commit_ref <= 1'b0;
            r_sec        <= 8'h00;
            r_min        <= 8'h00;
            r_hour       <= 8'h00;
            r_ad_out     <= 8'h00;
            r_ad_oe      <= 1'b0;
            r_a_d        <= 1'b0;
            r_cs_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_commit_ref <= rtc.commit;
            r_state      <= w_ns;
            r_idx        <= w_nidx;
            r_cnt        <= w_ncnt;
            // Snapshot inputs only on an accepted start; later edits are ignored.
            if ((r_state == S_IDLE) && w_start) begin
                r_sec  <= rtc.SC;
                r_min  <= rtc.MC;
                r_hour <= w_hour_in;
            end
            r_cs_n   <= ~w_phase;
            r_ad_oe  <= w_phase;
            r_a_d    <= w_dph;
            r_wr_n   <= ~w_wr;
            r_ad_out <= w_phase ? (w_dph ? w_data : w_addr) : 8'h00;
            r_busy   <= (w_ns != S_IDLE);
            r_done   <= (w_ns == S_DONE);
        end
    end

    assign rtc.ad_out = r_ad_out;
    assign rtc.ad_oe  = r_ad_oe;
    assign rtc.a_d    = r_a_d;
    assign rtc.cs_n   = r_cs_n;
    assign rtc.wr_n   = r_wr_n;
    assign rtc.rd_n   = 1'b1;
    assign rtc.busy   = r_busy;
    assign rtc.done   = r_done;

endmodule

// File: tb/tb_rtc_time_writer.sv
// Bench for rtc_time_writer: a cycle-indexed model derives every output from
// the elapsed time since an accepted commit edge; directed scenarios plus
// randomized sequences, with literal checks on bus pairs and latency.
module tb_rtc_time_writer;
    localparam int T    = 10;
    localparam int LAST = 24 * T + 1;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   en_cmp;

    rtc_time_writer_if rtc ();

    rtc_time_writer #(.T_PH(T)) dut (
        .clk   (clk),
        .reset (reset),
        .rtc   (rtc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- model: cycles elapsed since accepted start ----------------
    int         m_k;
    logic       m_prev;
    logic [7:0] m_dat [4];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k    <= 0;
            m_prev <= 1'b0;
        end else begin
            m_prev <= rtc.commit;
            if (m_k == 0) begin
                if (rtc.commit && !m_prev) begin
                    m_k      <= 1;
                    m_dat[0] <= rtc.SC;
                    m_dat[1] <= rtc.MC;
                    m_dat[2] <= rtc.format ? {rtc.AmPm, rtc.HC[6:0]} : rtc.HC;
                    m_dat[3] <= 8'hF2;
                end
            end else begin
                m_k <= (m_k == LAST) ? 0 : m_k + 1;
            end
        end
    end

    function automatic logic [7:0] addr_of(input int t);
        case (t)
            0: return 8'h21;
            1: return 8'h22;
            2: return 8'h23;
            default: return 8'hF2;
        endcase
    endfunction

    // {ad_out, ad_oe, a_d, cs_n, wr_n, rd_n, busy, done}
    function automatic logic [14:0] exp_out(input int k);
        int p, t, s;
        logic dp;
        logic [7:0] b;
        if (k == 0)    return {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        if (k == LAST) return {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        p  = (k - 1) / T;
        t  = p / 6;
        s  = p % 6;
        dp = (s >= 3);
        b  = dp ? m_dat[t] : addr_of(t);
        return {b, 1'b1, dp, 1'b0, !(s == 1 || s == 4), 1'b1, 1'b1, 1'b0};
    endfunction

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (en_cmp)
            chk($sformatf("out@%0d", cyc),
                {17'd0, rtc.ad_out, rtc.ad_oe, rtc.a_d, rtc.cs_n, rtc.wr_n, rtc.rd_n, rtc.busy, rtc.done},
                {17'd0, exp_out(m_k)});
    end

    // ---------------- bus capture for literal checks ----------------
    logic [8:0] capq [$];
    int         fallq [$];
    int         lenq [$];
    int         cur_len;
    logic       prev_wr;
    int         n_done;
    int         done_cyc;
    int         start_cyc;

    always @(negedge clk) begin
        if (prev_wr && !rtc.wr_n) begin
            capq.push_back({rtc.a_d, rtc.ad_out});
            fallq.push_back(cyc);
        end
        if (!rtc.wr_n) cur_len++;
        else if (!prev_wr) begin
            lenq.push_back(cur_len);
            cur_len = 0;
        end
        prev_wr = rtc.wr_n;
        if (rtc.done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic clear_cap();
        capq.delete();
        fallq.delete();
        lenq.delete();
        cur_len = 0;
    endtask

    task automatic start_seq(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                             input logic ap, input logic fmt);
        @(negedge clk);
        rtc.HC = h; rtc.MC = m; rtc.SC = s; rtc.AmPm = ap; rtc.format = fmt;
        rtc.commit = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int d0, i;
        d0 = n_done;
        i  = 0;
        while (n_done == d0 && i < LAST + 20) begin
            @(negedge clk); #1;
            i++;
        end
        chk({tag, "_done_seen"}, n_done - d0, 1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((rtc.busy || m_k != 0) && i < 2000) begin
            @(negedge clk); #1;
            i++;
        end
        chk("idle_reached", {31'd0, rtc.busy}, 0);
    endtask

    task automatic chk_pairs(input string tag, input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
        logic [8:0] ex [8];
        ex[0] = {1'b0, 8'h21}; ex[1] = {1'b1, s};
        ex[2] = {1'b0, 8'h22}; ex[3] = {1'b1, m};
        ex[4] = {1'b0, 8'h23}; ex[5] = {1'b1, h};
        ex[6] = {1'b0, 8'hF2}; ex[7] = {1'b1, 8'hF2};
        chk({tag, "_npulses"}, capq.size(), 8);
        if (capq.size() == 8)
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s_pair%0d", tag, i), {23'd0, capq[i]}, {23'd0, ex[i]});
    endtask

    initial begin
        int d0, bad_len;
        n_chk = 0; n_fail = 0; en_cmp = 0; cyc = 0;
        n_done = 0; cur_len = 0; prev_wr = 1'b1;
        reset = 1'b0;
        rtc.HC = 8'h00; rtc.MC = 8'h00; rtc.SC = 8'h00;
        rtc.AmPm = 1'b0; rtc.format = 1'b0; rtc.commit = 1'b0;

        // Reset held with commit toggling: nothing moves.
        #1 en_cmp = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rtc.commit = ~rtc.commit;
        end
        #1;
        chk("rst_cs_n", {31'd0, rtc.cs_n}, 1);
        chk("rst_wr_n", {31'd0, rtc.wr_n}, 1);
        chk("rst_ad_oe", {31'd0, rtc.ad_oe}, 0);
        @(negedge clk);
        rtc.commit = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 24 h write with latency and strobe-width checks.
        clear_cap();
        start_seq(8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
        wait_done("w24");
        chk("w24_done_latency", done_cyc - start_cyc, 241);
        chk("w24_first_wr_fall", (fallq.size() > 0) ? fallq[0] - start_cyc : -1, T + 1);
        chk_pairs("w24", 8'h58, 8'h59, 8'h23);
        bad_len = 0;
        foreach (lenq[i]) if (lenq[i] != T) bad_len++;
        chk("w24_wr_widths", {27'd0, 5'(lenq.size())} | (bad_len << 8), 8);
        @(negedge clk);
        rtc.commit = 1'b0;
        wait_idle();

        // 12 h: PM sets bit 7 of the hour byte, AM leaves it clear.
        clear_cap();
        start_seq(8'h11, 8'h07, 8'h33, 1'b1, 1'b1);
        wait_done("pm");
        chk("pm_hour", (capq.size() == 8) ? {23'd0, capq[5]} : 0, {23'd1, 8'h91});
        @(negedge clk); rtc.commit = 1'b0;
        wait_idle();
        clear_cap();
        start_seq(8'h11, 8'h07, 8'h33, 1'b0, 1'b1);
        wait_done("am");
        chk("am_hour", (capq.size() == 8) ? {23'd0, capq[5]} : 0, {23'd1, 8'h11});
        @(negedge clk); rtc.commit = 1'b0;
        wait_idle();

        // Input change and second commit edge mid-sequence are ignored.
        clear_cap();
        d0 = n_done;
        start_seq(8'h08, 8'h15, 8'h42, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rtc.SC = 8'h17; rtc.commit = 1'b0;
        while (cyc < start_cyc + 50) @(negedge clk);
        rtc.commit = 1'b1;
        @(negedge clk); rtc.commit = 1'b0;
        wait_done("mid");
        repeat (LAST + 20) @(negedge clk);
        #1;
        chk("mid_sec_orig", (capq.size() > 1) ? {23'd0, capq[1]} : 0, {23'd1, 8'h42});
        chk("mid_one_done", n_done - d0, 1);

        // Async reset during D_WR of the minutes transaction.
        start_seq(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        repeat (10 * T + 5) @(negedge clk);
        chk("ar_in_dwr", {23'd0, rtc.wr_n, rtc.ad_out}, {23'd0, 1'b0, 8'h34});
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("ar_cs_n", {31'd0, rtc.cs_n}, 1);
        chk("ar_wr_n", {31'd0, rtc.wr_n}, 1);
        chk("ar_ad_oe", {31'd0, rtc.ad_oe}, 0);
        @(negedge clk);
        rtc.commit = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_cap();
        start_seq(8'h21, 8'h43, 8'h05, 1'b0, 1'b0);
        wait_done("ar2");
        chk_pairs("ar2", 8'h05, 8'h43, 8'h21);
        @(negedge clk); rtc.commit = 1'b0;
        wait_idle();

        // Commit held high through and past done: exactly one sequence.
        d0 = n_done;
        start_seq(8'h09, 8'h09, 8'h09, 1'b0, 1'b0);
        wait_done("held");
        repeat (LAST + 20) @(negedge clk);
        #1;
        chk("held_one_done", n_done - d0, 1);
        @(negedge clk); rtc.commit = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized sequences with random commit chatter; model checks each cycle.
        for (int it = 0; it < 6; it++) begin
            wait_idle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_seq(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            for (int c = 0; c < LAST + 3; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) rtc.commit = ~rtc.commit;
                if ($urandom_range(0, 3) == 0) rtc.SC = 8'($urandom);
            end
            rtc.commit = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    // Hard stop well inside the cycle budget.
    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
